// File: rtl/alu_rr_arbiter.sv
// Round-robin front end for a single shared combinational ALU.
// One request is accepted at a time; the result comes back on a tagged response channel.
module alu_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 32,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    input  logic [NREQ*3-1:0]   req_op,
    output logic [W-1:0]        alu_a,
    output logic [W-1:0]        alu_b,
    output logic [2:0]          alu_op,
    input  logic [W-1:0]        alu_q,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [W-1:0]        rsp_data,
    output logic [IDW-1:0]      rsp_id,
    output logic                rsp_err,
    output logic                busy
);

    // state | meaning
    // IDLE  | waiting for a request; grant and capture operands
    // EXEC  | operands on the ALU; register the result
    // RESP  | response presented until rsp_ready
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]      state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  owner;
    logic [IDW-1:0]  grant;
    logic            found;
    logic [NREQ-1:0] rot;
    logic [NREQ-1:0] rot_k;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;
    logic [2:0]      sel_op;
    logic            illegal;
    int              idx;

    // Rotate the valid vector so bit 0 is the requester at rr_ptr, then take the first set bit.
    always_comb begin
        rot   = NREQ'({req_valid, req_valid} >> rr_ptr);
        rot_k = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            rot_k = rot >> k;
            if (!found && rot_k[0]) begin
                found = 1'b1;
                idx   = int'(rr_ptr) + k;
                if (idx >= NREQ) idx = idx - NREQ;
            end
        end
        grant = IDW'(idx);
    end

    assign sel_a   = W'(req_a >> (int'(grant) * W));
    assign sel_b   = W'(req_b >> (int'(grant) * W));
    assign sel_op  = 3'(req_op >> (int'(grant) * 3));
    assign illegal = (alu_op > 3'b100);

    // Gated by rst_n so a held request never sees ready while reset is asserted.
    assign req_ready = (rst_n && state == IDLE && found) ? (NREQ'(1) << grant) : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        alu_a  <= sel_a;
                        alu_b  <= sel_b;
                        alu_op <= sel_op;
                        owner  <= grant;
                        rr_ptr <= (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= illegal ? '0 : alu_q;
                    rsp_err   <= illegal;
                    rsp_id    <= owner;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
